// File: rtl/rf_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
// Requester indices fix the priority rotation order: ALU, load, host.
package rf_pkg;

    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int NREG = 32;

    localparam int REQ_ALU  = 0;
    localparam int REQ_LOAD = 1;
    localparam int REQ_HOST = 2;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Writeback request bundle: per-requester valid/addr/data in, one-hot ready out.
// master = requester side, slave = arbiter side.
interface rf_write_arbiter_if #(
    parameter int NREQ = 3,
    parameter int AW   = 5,
    parameter int DW   = 32
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;

    modport master (output req_valid, output req_addr, output req_data, input req_ready);
    modport slave  (input req_valid, input req_addr, input req_data, output req_ready);
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request after index 'last', wrapping.
// Zero latency; grant is zero when disabled or nothing requests.
module rr_arbiter #(
    parameter int NREQ = 3,
    parameter int LW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [LW-1:0]   last,
    input  logic            en,
    output logic [NREQ-1:0] gnt
);

    logic found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (int'(last) + k) % NREQ;
            if (en && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin owner of the register-file write port; optional RF_ARB_INIT_EN clears r0..r31 after reset.
// Grant is same-cycle combinational; a transfer drives rf_we/rf_Rw/rf_busW one cycle later.
module rf_write_arbiter #(
    parameter int NREQ = 3,
    parameter int AW   = rf_pkg::AW,
    parameter int DW   = rf_pkg::DW,
    parameter int LW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                clk,
    input  logic                rst,
    rf_write_arbiter_if.slave   req,
    output logic                rf_we,
    output logic [AW-1:0]       rf_Rw,
    output logic [DW-1:0]       rf_busW,
    output logic                init_busy
);

    import rf_pkg::*;

`ifdef RF_ARB_INIT_EN
    localparam state_t RST_STATE = INIT;
    localparam int     CW        = $clog2(NREG);
    logic [CW-1:0] cnt;
`else
    localparam state_t RST_STATE = RUN;
`endif

    state_t          state;
    logic [LW-1:0]   last;
    logic [NREQ-1:0] gnt;
    logic            xfer;
    logic [LW-1:0]   gnt_idx;
    logic [AW-1:0]   gnt_addr;
    logic [DW-1:0]   gnt_data;

    // Gating with rst makes reset win over a simultaneous request.
    rr_arbiter #(.NREQ(NREQ), .LW(LW)) u_rr (
        .req  (req.req_valid),
        .last (last),
        .en   ((state == RUN) && rst),
        .gnt  (gnt)
    );

    assign req.req_ready = gnt;
    assign xfer          = |(gnt & req.req_valid);

    always_comb begin
        gnt_idx  = '0;
        gnt_addr = '0;
        gnt_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                gnt_idx  = LW'(i);
                gnt_addr = req.req_addr[i*AW +: AW];
                gnt_data = req.req_data[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= RST_STATE;
            last    <= LW'(NREQ - 1);
            rf_we   <= 1'b0;
            rf_Rw   <= '0;
            rf_busW <= '0;
`ifdef RF_ARB_INIT_EN
            cnt     <= '0;
`endif
        end else begin
`ifdef RF_ARB_INIT_EN
            if (state == INIT) begin
                rf_we   <= 1'b1;
                rf_Rw   <= AW'(cnt);
                rf_busW <= '0;
                cnt     <= cnt + 1'b1;
                if (cnt == CW'(NREG - 1))
                    state <= RUN;
            end else
`endif
            if (xfer) begin
                last    <= gnt_idx;
                // r0 is hardwired zero: accept the transfer but never write it.
                rf_we   <= (gnt_addr != '0);
                rf_Rw   <= gnt_addr;
                rf_busW <= gnt_data;
            end else begin
                rf_we   <= 1'b0;
            end
        end
    end

`ifdef RF_ARB_INIT_EN
    assign init_busy = (state == INIT);
`else
    assign init_busy = 1'b0;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: init sweep (when RF_ARB_INIT_EN), vector table, reset mid-stream.
module tb_rf_write_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 5;
    localparam int DW   = 32;

`ifdef RF_ARB_INIT_EN
    localparam bit INIT_EN = 1'b1;
`else
    localparam bit INIT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rf_we;
    logic [AW-1:0] rf_Rw;
    logic [DW-1:0] rf_busW;
    logic init_busy;

    int n_chk  = 0;
    int n_fail = 0;

    rf_write_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

    rf_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (bus),
        .rf_we     (rf_we),
        .rf_Rw     (rf_Rw),
        .rf_busW   (rf_busW),
        .init_busy (init_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NREQ-1:0]    valid;
        logic [NREQ*AW-1:0] addr;
        logic [NREQ*DW-1:0] data;
        logic [NREQ-1:0]    ready;
        logic               we;
        logic               chk_bus;
        logic [AW-1:0]      rw;
        logic [DW-1:0]      busw;
    } vec_t;

    vec_t tv[17];

    function automatic vec_t mk(input logic [2:0] v, input logic [14:0] a, input logic [95:0] d,
                                input logic [2:0] r, input logic we, input logic cb,
                                input logic [4:0] rw, input logic [31:0] bw);
        vec_t t;
        t.valid = v; t.addr = a; t.data = d; t.ready = r;
        t.we = we; t.chk_bus = cb; t.rw = rw; t.busw = bw;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cycles;
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;

        tv[0]  = mk(3'b010, {5'd0, 5'd7, 5'd0}, {32'h0, 32'hDEADBEEF, 32'h0}, 3'b010, 0, 0, 5'd0, 32'h0);
        tv[1]  = mk(3'b000, {5'd0, 5'd7, 5'd0}, {32'h0, 32'hDEADBEEF, 32'h0}, 3'b000, 1, 1, 5'd7, 32'hDEADBEEF);
        tv[2]  = mk(3'b100, {5'd4, 5'd0, 5'd0}, {32'hA5A5, 32'h0, 32'h0},     3'b100, 0, 1, 5'd7, 32'hDEADBEEF);
        tv[3]  = mk(3'b111, {5'd3, 5'd2, 5'd1}, {32'h33, 32'h22, 32'h11},     3'b001, 1, 1, 5'd4, 32'hA5A5);
        tv[4]  = mk(3'b111, {5'd3, 5'd2, 5'd1}, {32'h33, 32'h22, 32'h11},     3'b010, 1, 1, 5'd1, 32'h11);
        tv[5]  = mk(3'b111, {5'd3, 5'd2, 5'd1}, {32'h33, 32'h22, 32'h11},     3'b100, 1, 1, 5'd2, 32'h22);
        tv[6]  = mk(3'b111, {5'd3, 5'd2, 5'd1}, {32'h33, 32'h22, 32'h11},     3'b001, 1, 1, 5'd3, 32'h33);
        tv[7]  = mk(3'b111, {5'd3, 5'd2, 5'd1}, {32'h33, 32'h22, 32'h11},     3'b010, 1, 1, 5'd1, 32'h11);
        tv[8]  = mk(3'b111, {5'd3, 5'd2, 5'd1}, {32'h33, 32'h22, 32'h11},     3'b100, 1, 1, 5'd2, 32'h22);
        tv[9]  = mk(3'b000, {5'd3, 5'd2, 5'd1}, {32'h33, 32'h22, 32'h11},     3'b000, 1, 1, 5'd3, 32'h33);
        tv[10] = mk(3'b001, {5'd0, 5'd0, 5'd0}, {32'h0, 32'h0, 32'h5},        3'b001, 0, 1, 5'd3, 32'h33);
        tv[11] = mk(3'b111, {5'd3, 5'd2, 5'd0}, {32'h33, 32'h22, 32'h5},      3'b010, 0, 0, 5'd0, 32'h0);
        tv[12] = mk(3'b000, {5'd3, 5'd2, 5'd0}, {32'h33, 32'h22, 32'h5},      3'b000, 1, 1, 5'd2, 32'h22);
        tv[13] = mk(3'b000, {5'd3, 5'd2, 5'd0}, {32'h33, 32'h22, 32'h5},      3'b000, 0, 1, 5'd2, 32'h22);
        tv[14] = mk(3'b011, {5'd0, 5'd6, 5'd5}, {32'h0, 32'h66, 32'h55},      3'b001, 0, 1, 5'd2, 32'h22);
        tv[15] = mk(3'b000, {5'd0, 5'd6, 5'd5}, {32'h0, 32'h66, 32'h55},      3'b000, 1, 1, 5'd5, 32'h55);
        tv[16] = mk(3'b000, {5'd0, 5'd6, 5'd5}, {32'h0, 32'h66, 32'h55},      3'b000, 0, 1, 5'd5, 32'h55);

        // Reset state
        tick();
        tick();
        chk("rst_we",        32'(rf_we),         32'd0);
        chk("rst_rw",        32'(rf_Rw),         32'd0);
        chk("rst_busw",      rf_busW,            32'd0);
        chk("rst_ready",     32'(bus.req_ready), 32'd0);
        chk("rst_init_busy", 32'(init_busy),     32'(INIT_EN));

        rst = 1'b1;
        if (INIT_EN) begin
            bus.req_valid = 3'b111;
            bus.req_addr  = {5'd3, 5'd2, 5'd1};
            #1;
            chk("init_pre_busy",  32'(init_busy),     32'd1);
            chk("init_pre_ready", 32'(bus.req_ready), 32'd0);
            chk("init_pre_we",    32'(rf_we),         32'd0);
            for (int c = 0; c < 32; c++) begin
                tick();
                if (c == 31) bus.req_valid = '0;
                #1;
                chk("init_we",    32'(rf_we),         32'd1);
                chk("init_rw",    32'(rf_Rw),         32'(c));
                chk("init_busw",  rf_busW,            32'd0);
                chk("init_busy",  32'(init_busy),     32'(c < 31));
                chk("init_ready", 32'(bus.req_ready), 32'd0);
            end
            tick();
            chk("init_end_we",   32'(rf_we),     32'd0);
            chk("init_end_busy", 32'(init_busy), 32'd0);
        end else begin
            bus.req_valid = 3'b100;
            bus.req_addr  = {5'd9, 5'd0, 5'd0};
            bus.req_data  = {32'h1234, 32'h0, 32'h0};
            #1;
            chk("noinit_first_ready", 32'(bus.req_ready), 32'b100);
            chk("noinit_busy",        32'(init_busy),     32'd0);
            tick();
            bus.req_valid = '0;
            chk("noinit_we",   32'(rf_we),  32'd1);
            chk("noinit_rw",   32'(rf_Rw),  32'd9);
            chk("noinit_busw", rf_busW,     32'h1234);
            tick();
        end

        for (int i = 0; i < 17; i++) begin
            bus.req_valid = tv[i].valid;
            bus.req_addr  = tv[i].addr;
            bus.req_data  = tv[i].data;
            #1;
            chk($sformatf("v%0d_ready", i), 32'(bus.req_ready), 32'(tv[i].ready));
            chk($sformatf("v%0d_we", i),    32'(rf_we),         32'(tv[i].we));
            if (tv[i].chk_bus) begin
                chk($sformatf("v%0d_rw", i),   32'(rf_Rw), 32'(tv[i].rw));
                chk($sformatf("v%0d_busw", i), rf_busW,    tv[i].busw);
            end
            tick();
        end

        // Reset asserted the cycle after a transfer, with all requesters valid
        bus.req_valid = 3'b010;
        bus.req_addr  = {5'd0, 5'd8, 5'd0};
        bus.req_data  = {32'h0, 32'h88, 32'h0};
        #1;
        chk("mid_ready", 32'(bus.req_ready), 32'b010);
        tick();
        rst = 1'b0;
        bus.req_valid = 3'b111;
        bus.req_addr  = {5'd3, 5'd2, 5'd1};
        #1;
        chk("mid_rst_ready", 32'(bus.req_ready), 32'd0);
        chk("mid_we",        32'(rf_we),         32'd1);
        chk("mid_rw",        32'(rf_Rw),         32'd8);
        tick();
        chk("mid_rst_we",   32'(rf_we),     32'd0);
        chk("mid_rst_rw",   32'(rf_Rw),     32'd0);
        chk("mid_rst_busy", 32'(init_busy), 32'(INIT_EN));
        rst = 1'b1;
        bus.req_valid = '0;
        if (INIT_EN) begin
            cycles = 0;
            while (init_busy && cycles < 40) begin
                tick();
                cycles++;
            end
            chk("reinit_cycles", 32'(cycles), 32'd32);
        end
        bus.req_valid = 3'b111;
        #1;
        chk("post_rst_ready", 32'(bus.req_ready), 32'b001);
        tick();
        bus.req_valid = '0;
        chk("post_rst_we", 32'(rf_we), 32'd1);
        chk("post_rst_rw", 32'(rf_Rw), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
